// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: byte-wide client on one side, serial pins on the other.
// TX and RX are independent FSMs sharing only the clock and reset.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] dataTX,
  input  logic       dataTXValid,
  output logic       serialTX,
  output logic       activeTX,
  output logic       doneTX,
  input  logic       serialRX,
  output logic [7:0] dataRX,
  output logic       dataRXValid,
  output logic [2:0] tx_state,
  output logic [2:0] rx_state
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  // Debug encoding exported on tx_state / rx_state; IDLE is always 0.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  // ---------------------------------------------------------------- TX
  // Handshake: dataTXValid is a request with no ready; it is taken only while
  // tx_state is IDLE (activeTX low and doneTX low), otherwise dropped.
  state_t        tx_cur, tx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt == LAST);
  assign tx_state   = tx_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_cur <= S_IDLE;
    else        tx_cur <= tx_nxt;
  end

  always_comb begin
    tx_nxt = tx_cur;
    case (tx_cur)
      S_IDLE:    if (dataTXValid) tx_nxt = S_START;
      S_START:   if (tx_bit_end) tx_nxt = S_DATA;
      S_DATA:    if (tx_bit_end && tx_idx == 3'd7) tx_nxt = S_STOP;
      S_STOP:    if (tx_bit_end) tx_nxt = S_CLEANUP;
      S_CLEANUP: tx_nxt = S_IDLE;
      default:   tx_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_cur == S_IDLE) begin
        tx_cnt <= '0;
        tx_idx <= '0;
        if (dataTXValid) tx_shift <= dataTX;
      end else if (tx_cur == S_CLEANUP || tx_bit_end) begin
        tx_cnt <= '0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
      // 3-bit index wraps 7 -> 0 as DATA is left.
      if (tx_cur == S_DATA && tx_bit_end) tx_idx <= tx_idx + 1'b1;
    end
  end

  always_comb begin
    serialTX = 1'b1;
    activeTX = 1'b0;
    doneTX   = 1'b0;
    case (tx_cur)
      S_START: begin
        serialTX = 1'b0;
        activeTX = 1'b1;
      end
      S_DATA: begin
        serialTX = tx_shift[tx_idx];
        activeTX = 1'b1;
      end
      S_STOP:    activeTX = 1'b1;
      S_CLEANUP: doneTX   = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic          rx_meta, rx_sync;
  state_t        rx_cur, rx_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_ferr;
  logic          rx_bit_end, rx_mid;

  assign rx_bit_end = (rx_cnt == LAST);
  assign rx_mid     = (rx_cnt == HALF);
  assign rx_state   = rx_cur;

  // Synchroniser resets to the idle (mark) level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= serialRX;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_cur <= S_IDLE;
    else        rx_cur <= rx_nxt;
  end

  always_comb begin
    rx_nxt = rx_cur;
    case (rx_cur)
      S_IDLE:    if (!rx_sync) rx_nxt = S_START;
      S_START:   if (rx_mid) rx_nxt = rx_sync ? S_IDLE : S_DATA;
      S_DATA:    if (rx_bit_end && rx_idx == 3'd7) rx_nxt = S_STOP;
      S_STOP:    if (rx_bit_end) rx_nxt = S_CLEANUP;
      S_CLEANUP: if (!rx_ferr || rx_sync) rx_nxt = S_IDLE;
      default:   rx_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_ferr  <= 1'b0;
      dataRX   <= 8'h00;
    end else begin
      case (rx_cur)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
        end
        S_START: rx_cnt <= rx_mid ? '0 : rx_cnt + 1'b1;
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt           <= '0;
            rx_shift[rx_idx] <= rx_sync;
            rx_idx           <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_cnt  <= '0;
            rx_ferr <= ~rx_sync;
            if (rx_sync) dataRX <= rx_shift;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_CLEANUP: begin
          rx_cnt <= '0;
          if (rx_nxt == S_IDLE) rx_ferr <= 1'b0;
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  // A well-framed byte spends exactly one cycle in CLEANUP, giving a single-cycle pulse.
  always_comb begin
    dataRXValid = 1'b0;
    if (rx_cur == S_CLEANUP && !rx_ferr) dataRXValid = 1'b1;
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed-plus-random bench for uart_txrx: loopback frames, direct RX frames,
// glitch, framing error, clock-skewed frames and asynchronous reset.
module tb_uart_txrx;

  localparam int         C       = 87;
  localparam int         H       = (C - 1) / 2;
  localparam int         RX_LAT  = 2 + H + 9 * C + 1;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dataTX = 8'h00;
  logic       dataTXValid = 1'b0;
  logic       serialTX, activeTX, doneTX, serialRX;
  logic [7:0] dataRX;
  logic       dataRXValid;
  logic [2:0] tx_state, rx_state;

  logic       loop = 1'b0;
  logic       rx_line = 1'b1;
  assign serialRX = loop ? serialTX : rx_line;

  int         tests_run = 0;
  int         failed = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         lat_last = -1;
  int         stable_bad = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];

  uart_txrx #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dataTX      (dataTX),
    .dataTXValid (dataTXValid),
    .serialTX    (serialTX),
    .activeTX    (activeTX),
    .doneTX      (doneTX),
    .serialRX    (serialRX),
    .dataRX      (dataRX),
    .dataRXValid (dataRXValid),
    .tx_state    (tx_state),
    .rx_state    (rx_state)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rx <= 8'h00;
    end else if (dataRXValid === 1'b1) begin
      lat_last <= cyc - fall_cyc;
      check("rx_pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rx_data", 32'(dataRX), 32'(exp_q.pop_front()));
      last_rx <= dataRX;
    end else if (dataRX !== last_rx) begin
      stable_bad <= stable_bad + 1;
    end
  end

  // ---------------------------------------------------------------- drivers
  // Requests one frame and checks every cycle of the serial waveform against
  // the 10-bit frame image; optionally pulses a competing request mid-frame.
  task automatic send_frame(input logic [7:0] b, input int inject_at, input logic expect_rx);
    int         bad;
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    dataTX      = b;
    dataTXValid = 1'b1;
    @(negedge clk);
    dataTXValid = 1'b0;
    dataTX      = 8'($urandom);
    if (expect_rx) begin
      exp_q.push_back(b);
      last_good = b;
    end
    bad = 0;
    for (int c = 0; c < 10 * C; c++) begin
      if (serialTX !== frame[c / C] || activeTX !== 1'b1 || doneTX !== 1'b0) bad++;
      if (c == inject_at) begin
        dataTX      = 8'hA5;
        dataTXValid = 1'b1;
      end else begin
        dataTXValid = 1'b0;
      end
      @(negedge clk);
    end
    dataTXValid = 1'b0;
    check("tx_frame_bad_cycles", 32'(bad), 32'd0);
    check("tx_done_pulse", 32'(doneTX), 32'd1);
    check("tx_active_in_done", 32'(activeTX), 32'd0);
    check("tx_line_in_done", 32'(serialTX), 32'd1);
  endtask

  // Drives one frame straight onto serialRX with an arbitrary bit period.
  task automatic drive_rx(input logic [7:0] b, input logic stop, input int period);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end
    @(negedge clk);
    fall_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      rx_line = frame[k];
      repeat (period) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    repeat (3) @(negedge clk);
    check("rst_serialTX", 32'(serialTX), 32'd1);
    check("rst_activeTX", 32'(activeTX), 32'd0);
    check("rst_doneTX", 32'(doneTX), 32'd0);
    check("rst_dataRX", 32'(dataRX), 32'h00);
    check("rst_dataRXValid", 32'(dataRXValid), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_tx_state", 32'(tx_state), 32'(ST_IDLE));
    check("idle_rx_state", 32'(rx_state), 32'(ST_IDLE));

    // loopback 0x55, then back-to-back 0x00 / 0xFF
    loop = 1'b1;
    send_frame(8'h55, -1, 1'b1);
    check("loop55_rx", 32'(dataRX), 32'h55);
    send_frame(8'h00, -1, 1'b1);
    send_frame(8'hFF, -1, 1'b1);
    check("b2b_rx_last", 32'(dataRX), 32'hFF);
    repeat (5) @(negedge clk);

    // competing request during an active 0x3C frame
    send_frame(8'h3C, 300, 1'b1);
    repeat (3) @(negedge clk);
    check("ignored_req_idle", 32'(activeTX), 32'd0);
    check("ignored_req_rx", 32'(dataRX), 32'h3C);

    for (int i = 0; i < 4; i++) send_frame(8'($urandom), $urandom_range(0, 10 * C - 2), 1'b1);
    check("loop_rand_queue", 32'(exp_q.size()), 32'd0);

    // direct RX at nominal rate, with latency from the falling start edge
    loop = 1'b0;
    repeat (5) @(negedge clk);
    drive_rx(8'h5A, 1'b1, C);
    repeat (20) @(negedge clk);
    check("rx_5A", 32'(dataRX), 32'h5A);
    check("rx_latency", 32'(lat_last >= RX_LAT - 1 && lat_last <= RX_LAT + 1), 32'd1);

    // TX and RX at the same time, independent bytes
    fork
      send_frame(8'($urandom), -1, 1'b0);
      begin
        repeat (100) @(negedge clk);
        drive_rx(8'($urandom), 1'b1, C);
      end
    join
    repeat (20) @(negedge clk);
    check("duplex_queue", 32'(exp_q.size()), 32'd0);

    // +/-4% bit period
    for (int i = 0; i < 4; i++) begin
      drive_rx(8'($urandom), 1'b1, (i % 2 == 0) ? C - 3 : C + 3);
      repeat (30) @(negedge clk);
    end
    check("skew_queue", 32'(exp_q.size()), 32'd0);

    // 20-cycle glitch on an idle line
    rx_line = 1'b0;
    repeat (20) @(negedge clk);
    rx_line = 1'b1;
    repeat (C) @(negedge clk);
    check("glitch_rx_idle", 32'(rx_state), 32'(ST_IDLE));
    check("glitch_dataRX_hold", 32'(dataRX), 32'(last_good));

    // framing error, then a good frame
    drive_rx(8'h81, 1'b0, C);
    repeat (20) @(negedge clk);
    check("ferr_rx_idle", 32'(rx_state), 32'(ST_IDLE));
    check("ferr_dataRX_hold", 32'(dataRX), 32'(last_good));
    drive_rx(8'h42, 1'b1, C);
    repeat (20) @(negedge clk);
    check("after_ferr_rx", 32'(dataRX), 32'h42);

    // asynchronous reset in the middle of a loopback frame
    loop = 1'b1;
    @(negedge clk);
    dataTX      = 8'hC3;
    dataTXValid = 1'b1;
    @(negedge clk);
    dataTXValid = 1'b0;
    repeat (300) @(negedge clk);
    check("pre_reset_active", 32'(activeTX), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_serialTX", 32'(serialTX), 32'd1);
    check("midrst_activeTX", 32'(activeTX), 32'd0);
    check("midrst_doneTX", 32'(doneTX), 32'd0);
    check("midrst_dataRX", 32'(dataRX), 32'h00);
    check("midrst_dataRXValid", 32'(dataRXValid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * C) @(negedge clk);
    check("post_rst_serialTX", 32'(serialTX), 32'd1);
    check("post_rst_tx_state", 32'(tx_state), 32'(ST_IDLE));
    check("post_rst_dataRX", 32'(dataRX), 32'h00);

    check("rx_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rx_data_stable", 32'(stable_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

Full-duplex 8N1 UART core: a transmitter serialises one byte per request and a receiver recovers bytes from an asynchronous serial input. Both halves run from one system clock, and the bit period is set in clock cycles by a parameter. The block sits between a byte-wide parallel client and the external serial pins. In loopback test setups `serialTX` is tied to `serialRX`.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per serial bit (87 gives 115200 baud at 10 MHz); legal range ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `dataTX`  in  8  byte to transmit; sampled when the request is accepted.
- `dataTXValid`  in  1  transmit request; accepted only in TX IDLE.
- `serialTX`  out  1  serial output; idles high.
- `activeTX`  out  1  high while a frame is being transmitted.
- `doneTX`  out  1  one-cycle pulse when a frame completes.
- `serialRX`  in  1  asynchronous serial input.
- `dataRX`  out  8  last correctly framed received byte.
- `dataRXValid`  out  1  one-cycle pulse when `dataRX` is updated.

## Operation
- Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1). No parity.
- Bit counter width: $clog2(CLKS_PER_BIT).
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: `serialTX`=1, `activeTX`=0. On `dataTXValid`=1, latch `dataTX`, set `activeTX`=1, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive bits 0..7, CLKS_PER_BIT cycles each. A 3-bit index wraps 7→0 on exit.
  - STOP: drive 1 for CLKS_PER_BIT cycles.
  - CLEANUP: one cycle with `doneTX`=1 and `activeTX`=0, then go to IDLE.
- TX request handling: `dataTXValid` is ignored outside IDLE; no queuing. Changes to `dataTX` after acceptance have no effect.
- RX input synchronisation: `serialRX` passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: on a synchronised 0, go to START.
  - START: at count (CLKS_PER_BIT-1)/2 (mid start bit), if the line is still 0, reset the counter and go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), sample into bit index 0..7, then go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit. If 1, load `dataRX` with the shift byte and pulse `dataRXValid`. If 0 (framing error), discard the byte: no pulse and `dataRX` unchanged.
  - CLEANUP: one cycle, then go to IDLE. After a framing error, stay in CLEANUP until the line reads 1.
- `dataRX` holds its value between frames.
- TX and RX are fully independent and may operate simultaneously.

## Timing
- Reset (async assert, sync-safe deassert): `serialTX`=1, `activeTX`=0, `doneTX`=0, `dataRX`=8'h00, `dataRXValid`=0; both FSMs in IDLE; counters cleared.
- Reset mid-frame: the frame is abandoned and `serialTX` returns high immediately.
- TX request to start bit: request sampled at edge N; `serialTX` falls and `activeTX` rises after edge N.
- TX frame length: the frame lasts exactly 10×CLKS_PER_BIT cycles. `doneTX` is high for the single cycle after the stop bit.
- TX back-to-back: the earliest next request is accepted in the cycle after `doneTX`.
- RX latency: `dataRXValid` asserts 2 + (CLKS_PER_BIT-1)/2 + 9×CLKS_PER_BIT + 1 cycles (±1) after the start-bit falling edge on `serialRX`, i.e. mid stop bit.
- RX readiness: RX is back in IDLE before the stop bit ends, so it is ready for an immediately following start bit.
- RX output timing: `dataRXValid` is a single-cycle pulse. `dataRX` is valid in that cycle and stays stable after it.
- Clock tolerance: RX tolerates ±4% clock mismatch between transmitter and receiver.

## Test plan
- Reset: assert `rst_n`=0 mid-frame → `serialTX`=1, `activeTX`=0, `doneTX`=0, `dataRX`=0x00, `dataRXValid`=0 immediately.
- Loopback 0x55: `serialTX`→`serialRX`, CLKS_PER_BIT=87, one-cycle `dataTXValid` with 0x55 → `serialTX` pattern 0,1,0,1,0,1,0,1,0,1 per 87 cycles. Within 15×87 cycles: `dataRX`=0x55 with one `dataRXValid` pulse and one `doneTX` pulse.
- Back-to-back TX: send 0x00 then 0xFF, issuing the second request in the cycle after `doneTX` → frames are contiguous (each 870 cycles) and RX delivers 0x00 then 0xFF.
- Ignored request: pulse `dataTXValid` with 0xA5 during an active 0x3C frame → only 0x3C is transmitted, and `activeTX` never drops mid-frame.
- RX glitch: drive a low pulse of 20 cycles on idle `serialRX` → no `dataRXValid` pulse and RX returns to IDLE.
- Framing error: drive a frame carrying 0x81 with stop bit=0, then line high, then a valid 0x42 frame → no pulse for the first frame, `dataRX`=0x42 after the second.
